// File: rtl/uart_tx_sched_pkg.sv
// ============================================================================
// Module      : uart_tx_sched_pkg
// Description : Shared state encoding and default sizing for uart_tx_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } sched_state_e;

    localparam int DEFAULT_NUM_REQ     = 2;
    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first active request at or
//               above the pointer, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_grant_o
);

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] sel;
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDX_W'(idx);
            if (!any_grant_o && req_i[sel]) begin
                any_grant_o  = 1'b1;
                grant_o[sel] = 1'b1;
                grant_idx_o  = sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module      : uart_tx_sched
// Description : Round-robin scheduler sharing one UART transmitter among
//               NUM_REQ requesters; one grant per transmitted frame.
//               Optional WAIT_HI watchdog: define UART_TX_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      uart_tx_en,
    output logic [DATA_W-1:0]         uart_tx_data,
    input  logic                      uart_tx_busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      sched_busy,
    output logic                      tx_timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("uart_tx_sched: unsupported parameter set");
    end

    sched_state_e        state_q, state_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                en_q, en_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    gid_q, gid_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [IDX_W-1:0]    ptr_after;
    logic                wait_hi_expired;
    logic [DATA_W-1:0]   req_word [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_grant_o (arb_any)
    );

    // Priority moves to the requester just after the one that owned the frame.
    assign ptr_after = (gid_q == IDX_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // Terminal count is offset so the error pulse lands TIMEOUT_CYC cycles
    // after the launch pulse (LAUNCH plus the first WAIT_HI cycle).
    assign wait_hi_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == WAIT_HI) ? cnt_q + 1'b1 : '0;
            timeout_q <= (state_q == WAIT_HI) && !uart_tx_busy && wait_hi_expired;
        end
    end

    assign tx_timeout = timeout_q;
`else
    assign wait_hi_expired = 1'b0;
    assign tx_timeout      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = '0;
        en_d    = 1'b0;
        data_d  = data_q;
        gid_d   = gid_q;
        case (state_q)
            IDLE: begin
                if (arb_any && !uart_tx_busy) begin
                    state_d = LAUNCH;
                    ready_d = arb_grant;
                    en_d    = 1'b1;
                    data_d  = req_word[arb_idx];
                    gid_d   = arb_idx;
                end
            end
            LAUNCH: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_LO;
                end else if (wait_hi_expired) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after;
                end
            end
            WAIT_LO: begin
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ready_q <= '0;
            en_q    <= 1'b0;
            data_q  <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
        end
    end

    assign req_ready    = ready_q;
    assign uart_tx_en   = en_q;
    assign uart_tx_data = data_q;
    assign grant_id     = gid_q;
    assign sched_busy   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Randomised scoreboard bench for uart_tx_sched (NUM_REQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           uart_tx_en;
    logic [W-1:0]   uart_tx_data;
    logic           uart_tx_busy;
    logic [1:0]     grant_id;
    logic           sched_busy;
    logic           tx_timeout;

    logic           tx_busy_m;
    logic           ext_busy;
    assign uart_tx_busy = tx_busy_m | ext_busy;

    uart_tx_sched #(
        .NUM_REQ      (N),
        .DATA_W       (W),
        .TIMEOUT_CYC  (16)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .grant_id     (grant_id),
        .sched_busy   (sched_busy),
        .tx_timeout   (tx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester behaviour knobs, set by the main sequence.
    logic [N-1:0] mask;
    bit           cont;
    bit           fixed_data_en;
    bit           tx_fixed;
    int           p_raise;
    int           p_withdraw;
    int           issue_left;
    logic [W-1:0] fixed_data [N];

    // Scoreboard: words each requester has offered but not yet had accepted.
    logic [W-1:0] pend [N][$];
    int           grants [$];
    int           en_count = 0;

    task automatic raise(input int i);
        logic [W-1:0] w;
        w = fixed_data_en ? fixed_data[i] : W'($urandom);
        req_data[i*W +: W] = w;
        req_valid[i] = 1'b1;
        pend[i].push_back(w);
        issue_left--;
    endtask

    // Requesters
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!mask[i]) continue;
                if (req_ready[i]) begin
                    if (cont && issue_left > 0) raise(i);
                    else req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if (int'($urandom_range(99)) < p_withdraw) begin
                        req_valid[i] = 1'b0;
                        pend[i].delete();
                    end
                end else if (issue_left > 0 && int'($urandom_range(99)) < p_raise) begin
                    raise(i);
                end
            end
        end
    end

    // Transmitter model: busy rises some cycles after each launch pulse.
    initial begin
        int d;
        int h;
        tx_busy_m = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx_en === 1'b1) begin
                d = tx_fixed ? 2  : int'($urandom_range(3, 1));
                h = tx_fixed ? 10 : int'($urandom_range(8, 2));
                repeat (d) @(posedge clk);
                #1 tx_busy_m = 1'b1;
                repeat (h) @(posedge clk);
                #1 tx_busy_m = 1'b0;
            end
        end
    end

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Monitor / reference model
    initial begin
        logic [N-1:0] prev_valid;
        logic         prev_busy;
        logic         prev_rst;
        logic [W-1:0] launched;
        logic [W-1:0] exp_w;
        int           ptr_m;
        int           since_close;
        int           w;
        bit           frame_open;
        bit           saw_hi;
        bit           exp_en;
        prev_valid  = '0;
        prev_busy   = 1'b0;
        prev_rst    = 1'b1;
        launched    = '0;
        ptr_m       = 0;
        since_close = 2;
        frame_open  = 1'b0;
        saw_hi      = 1'b0;
        forever begin
            @(negedge clk);
            chk(tx_timeout == 1'b0, "tx_timeout_idle", tx_timeout, 0);
            if (prev_rst) begin
                chk(req_ready == '0,    "rst_ready",      req_ready, 0);
                chk(uart_tx_en == 1'b0, "rst_en",         uart_tx_en, 0);
                chk(uart_tx_data == '0, "rst_data",       uart_tx_data, 0);
                chk(grant_id == '0,     "rst_grant_id",   grant_id, 0);
                chk(sched_busy == 1'b0, "rst_sched_busy", sched_busy, 0);
                ptr_m       = 0;
                frame_open  = 1'b0;
                saw_hi      = 1'b0;
                since_close = 2;
            end else begin
                if (since_close < 100) since_close++;
                // A grant needs a request and an idle transmitter seen the
                // cycle before, and one settle cycle after the last frame.
                exp_en = !frame_open && since_close >= 2 && (prev_valid != '0) && !prev_busy;
                chk(uart_tx_en == exp_en, "launch_timing", uart_tx_en, exp_en);
                chk(sched_busy == (frame_open || exp_en), "sched_busy", sched_busy, frame_open || exp_en);
                if (uart_tx_en) begin
                    w = pick(prev_valid, ptr_m);
                    if (w < 0) begin
                        chk(1'b0, "winner_exists", prev_valid, 1);
                    end else begin
                        chk(grant_id == 2'(w), "grant_id", grant_id, w);
                        chk(req_ready == N'(1 << w), "ready_onehot", req_ready, 1 << w);
                        if (pend[w].size() == 0) begin
                            chk(1'b0, "pending_word", 0, 1);
                        end else begin
                            exp_w = pend[w].pop_front();
                            chk(uart_tx_data == exp_w, "tx_data", uart_tx_data, exp_w);
                            launched = exp_w;
                        end
                        grants.push_back(w);
                        ptr_m = (w + 1) % N;
                    end
                    en_count++;
                    frame_open = 1'b1;
                    saw_hi     = 1'b0;
                end else begin
                    chk(req_ready == '0, "ready_idle", req_ready, 0);
                    if (frame_open) begin
                        chk(uart_tx_data == launched, "tx_data_stable", uart_tx_data, launched);
                        if (uart_tx_busy) begin
                            saw_hi = 1'b1;
                        end else if (saw_hi) begin
                            frame_open  = 1'b0;
                            since_close = 0;
                        end
                    end
                end
            end
            prev_valid = req_valid;
            prev_busy  = uart_tx_busy;
            prev_rst   = rst;
        end
    end

    task automatic wait_grants(input int n, input int budget);
        int c = 0;
        while (grants.size() < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (grants.size() < n) chk(1'b0, "grant_wait_timeout", grants.size(), n);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        issue_left = 0;
        cont       = 1'b0;
        while ((req_valid != '0 || sched_busy || uart_tx_busy) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= budget) chk(1'b0, "drain_timeout", c, budget);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int base;
        int c;
        rst           = 1'b1;
        ext_busy      = 1'b0;
        mask          = '0;
        cont          = 1'b0;
        fixed_data_en = 1'b1;
        tx_fixed      = 1'b1;
        p_raise       = 100;
        p_withdraw    = 0;
        issue_left    = 0;
        fixed_data[0] = 8'h5A;
        fixed_data[1] = 8'h22;
        fixed_data[2] = 8'h33;
        fixed_data[3] = 8'h44;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single requester, one frame
        mask = 4'b0001;
        issue_left = 1;
        wait_grants(1, 200);
        drain(500);
        chk(en_count == 1, "single_en_count", en_count, 1);

        // Transmitter busy while idle: no grant until it clears
        fixed_data_en = 1'b0;
        ext_busy = 1'b1;
        issue_left = 1;
        repeat (10) @(posedge clk);
        #1;
        chk(en_count == 1, "no_grant_while_busy", en_count, 1);
        ext_busy = 1'b0;
        wait_grants(2, 50);
        drain(500);

        // Two requesters held valid: alternate 0x11 / 0x22
        do_reset();
        fixed_data_en = 1'b1;
        fixed_data[0] = 8'h11;
        fixed_data[1] = 8'h22;
        mask = 4'b0011;
        cont = 1'b1;
        base = grants.size();
        issue_left = 1000;
        wait_grants(base + 4, 400);
        for (int k = 0; k < 4 && base + k < grants.size(); k++)
            chk(grants[base + k] == k % 2, "alternate_order", grants[base + k], k % 2);
        drain(1000);

        // Four requesters continuously valid for eight frames
        do_reset();
        fixed_data_en = 1'b0;
        mask = 4'b1111;
        cont = 1'b1;
        base = grants.size();
        issue_left = 1000;
        wait_grants(base + 8, 800);
        for (int k = 0; k < 8 && base + k < grants.size(); k++)
            chk(grants[base + k] == k % 4, "rr_order_4", grants[base + k], k % 4);
        drain(2000);

        // Reset while waiting for busy to fall; priority returns to 0
        mask = 4'b0010;
        issue_left = 1;
        base = grants.size();
        wait_grants(base + 1, 200);
        if (grants.size() > base) chk(grants[base] == 1, "pre_reset_grant", grants[base], 1);
        c = 0;
        while (!uart_tx_busy && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(sched_busy == 1'b1, "busy_before_reset", sched_busy, 1);
        do_reset();
        mask = 4'b0011;
        issue_left = 2;
        base = grants.size();
        wait_grants(base + 1, 200);
        if (grants.size() > base) chk(grants[base] == 0, "post_reset_winner", grants[base], 0);
        drain(1000);

        // Randomised traffic with withdrawals and random frame timing
        tx_fixed   = 1'b0;
        mask       = 4'b1111;
        p_raise    = 30;
        p_withdraw = 5;
        issue_left = 80;
        c = 0;
        while (issue_left > 0 && c < 20000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (issue_left > 0) chk(1'b0, "random_phase_timeout", issue_left, 0);
        drain(5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
